serial_add_ctrl: RTL

- Bit-serial adder sequencer built around one instance of the team's decoder-based 1-bit full adder (FA).
- Adds two WIDTH-bit operands plus carry-in over WIDTH clock cycles, one bit per cycle, LSB first.
- Carry is held in a register between cycles.
- Sits between a requesting controller (start/done handshake) and the shared FA datapath; trades area for latency.

---
 rtl/serial_add_ctrl_if.sv | 24 ++
 rtl/serial_add_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a controller and the bit-serial adder.
// The master drives the operands and start; the slave reports status and result.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one decoder-based full adder is reused for
// WIDTH cycles, LSB first, with the carry held in a register between bits.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands are captured on the accepting edge
// RUN   | one bit per edge through the shared full adder (WIDTH edges)
// DONE  | one-cycle done pulse; sum/cout already valid; start ignored

// Full adder built from a 3-to-8 minterm decoder.
module serial_add_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic sum_o,
   output logic cout_o
);
   logic [7:0] dec;

   // One-hot minterm decode, then OR the minterms of each output.
   always_comb begin
      dec    = 8'b0000_0001 << {a_i, b_i, c_i};
      sum_o  = dec[1] | dec[2] | dec[4] | dec[7];
      cout_o = dec[3] | dec[5] | dec[6] | dec[7];
   end
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   serial_add_ctrl_if.slave  add_if
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sha_q;
   logic [WIDTH-1:0] shb_q;
   logic [WIDTH-1:0] shr_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             cout_q;
   logic             busy_q;
   logic             done_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH-1:0] sha_d;
   logic [WIDTH-1:0] shb_d;
   logic [WIDTH-1:0] shr_d;
   logic [CW-1:0]    cnt_d;
   logic             last_bit;
   logic             fa_sum;
   logic             fa_cout;

   serial_add_fa u_fa (
      .a_i    (sha_q[0]),
      .b_i    (shb_q[0]),
      .c_i    (carry_q),
      .sum_o  (fa_sum),
      .cout_o (fa_cout)
   );

   // Next values of the shift registers and bit counter during RUN.
   // Shifts (rather than slices) keep WIDTH=1 legal: the new bit lands in bit 0.
   always_comb begin
      sha_d    = sha_q >> 1;
      shb_d    = shb_q >> 1;
      shr_d    = (shr_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
      cnt_d    = cnt_q + CW'(1);
      last_bit = (cnt_q == CW'(WIDTH - 1));
   end

   // Sequencer FSM with registered status and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sha_q   <= '0;
         shb_q   <= '0;
         shr_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (add_if.start) begin
                  sha_q   <= add_if.a;
                  shb_q   <= add_if.b;
                  carry_q <= add_if.cin;
                  cnt_q   <= '0;
                  shr_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sha_q   <= sha_d;
               shb_q   <= shb_d;
               shr_q   <= shr_d;
               carry_q <= fa_cout;
               cnt_q   <= cnt_d;
               if (last_bit) begin
                  // Publish only the complete word so partial sums never show.
                  sum_q   <= shr_d;
                  cout_q  <= fa_cout;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign add_if.busy = busy_q;
   assign add_if.done = done_q;
   assign add_if.sum  = sum_q;
   assign add_if.cout = cout_q;
endmodule
